// File: rtl/gpreg_bank_swap.sv
// gpreg_bank_swap: exchanges R0..R7 with the banked copies CC8..CC15 whenever
// the requested register bank differs from the resident one, stalling the
// pipeline meanwhile; otherwise a transparent path to the GPR file.
// Optional build macro GPREG_SWAP_OVERLAP_EN merges each pair's live-register
// write with the next pair's live-register read (2*NPAIRS+1 busy cycles
// instead of 3*NPAIRS).
module gpreg_bank_swap #(
    parameter int unsigned NPAIRS    = 8,
    parameter logic [6:0]  REG_BASE  = 7'h00,
    parameter logic [6:0]  BANK_BASE = 7'h58
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqBank,
    output logic        curBank,
    output logic        swapBusy,
    output logic        dropErr,
    input  logic        pipeIsWr,
    input  logic        pipeIsQw,
    input  logic [6:0]  pipeIdRegD,
    input  logic [63:0] pipeDataD,
    input  logic [6:0]  pipeIdReg3,
    output logic [63:0] pipeData3,
    output logic        rfIsWr,
    output logic        rfIsQw,
    output logic [6:0]  rfIdRegD,
    output logic [63:0] rfDataD,
    output logic [6:0]  rfIdReg3,
    input  logic [63:0] rfData3
);

    localparam int unsigned IDX_W = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPAIRS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_R   = 3'd1,
        XCHG_C = 3'd2,
        WR_R   = 3'd3,
        WR_RD  = 3'd4
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [63:0]      tmpA;
    logic [63:0]      tmpB;
    logic [6:0]       regId;
    logic [6:0]       bankId;

    // Register IDs of the pair being exchanged; 7-bit wrap is intentional
    assign regId  = REG_BASE + 7'(idx);
    assign bankId = BANK_BASE + 7'(idx);

`ifdef GPREG_SWAP_OVERLAP_EN
    logic [6:0] regIdNext;
    assign regIdNext = regId + 7'd1;
`endif

    // A pipeline write arriving while the swap owns the write port is lost
    assign dropErr = swapBusy & pipeIsWr;

    // Swap sequencer: reads live reg, exchanges with banked reg, writes back
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            curBank  <= 1'b0;
            swapBusy <= 1'b0;
            idx      <= '0;
            tmpA     <= '0;
            tmpB     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqBank != curBank) begin
                        state    <= RD_R;
                        idx      <= '0;
                        swapBusy <= 1'b1;
                    end
                end
                RD_R: begin
                    tmpA  <= rfData3;
                    state <= XCHG_C;
                end
                XCHG_C: begin
                    tmpB <= rfData3;
`ifdef GPREG_SWAP_OVERLAP_EN
                    state <= (idx == LAST_IDX) ? WR_R : WR_RD;
`else
                    state <= WR_R;
`endif
                end
                WR_R: begin
                    if (idx == LAST_IDX) begin
                        state    <= IDLE;
                        idx      <= '0;
                        curBank  <= ~curBank;
                        swapBusy <= 1'b0;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= RD_R;
                    end
                end
`ifdef GPREG_SWAP_OVERLAP_EN
                WR_RD: begin
                    tmpA  <= rfData3;
                    idx   <= idx + IDX_W'(1);
                    state <= XCHG_C;
                end
`endif
                default: begin
                    state    <= IDLE;
                    swapBusy <= 1'b0;
                end
            endcase
        end
    end

    // GPR port steering: pass-through when idle, swap moves when busy
    always_comb begin
        rfIsWr    = pipeIsWr;
        rfIsQw    = pipeIsQw;
        rfIdRegD  = pipeIdRegD;
        rfDataD   = pipeDataD;
        rfIdReg3  = pipeIdReg3;
        pipeData3 = rfData3;
        if (state != IDLE) begin
            rfIsWr    = 1'b0;
            rfIsQw    = 1'b0;
            rfIdRegD  = '0;
            rfDataD   = '0;
            rfIdReg3  = '0;
            pipeData3 = '0;
            case (state)
                RD_R: begin
                    rfIdReg3 = regId;
                end
                XCHG_C: begin
                    rfIdReg3 = bankId;
                    rfIsWr   = 1'b1;
                    rfIsQw   = 1'b1;
                    rfIdRegD = bankId;
                    rfDataD  = tmpA;
                end
                WR_R: begin
                    rfIsWr   = 1'b1;
                    rfIsQw   = 1'b1;
                    rfIdRegD = regId;
                    rfDataD  = tmpB;
                end
`ifdef GPREG_SWAP_OVERLAP_EN
                WR_RD: begin
                    rfIsWr   = 1'b1;
                    rfIsQw   = 1'b1;
                    rfIdRegD = regId;
                    rfDataD  = tmpB;
                    rfIdReg3 = regIdNext;
                end
`endif
                default: begin
                    rfIsWr = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpreg_bank_swap.sv
// Bench for gpreg_bank_swap: a behavioural GPR file, a register-level
// reference image, table-driven idle pass-through vectors, hand-written
// swap corner cases and a randomized write/swap mix.
module tb_gpreg_bank_swap;

    localparam int NP = 8;
    localparam logic [6:0] RB = 7'h00;
    localparam logic [6:0] BB = 7'h58;
`ifdef GPREG_SWAP_OVERLAP_EN
    localparam int BUSY = 2 * NP + 1;
`else
    localparam int BUSY = 3 * NP;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        reqBank;
    logic        curBank;
    logic        swapBusy;
    logic        dropErr;
    logic        pipeIsWr;
    logic        pipeIsQw;
    logic [6:0]  pipeIdRegD;
    logic [63:0] pipeDataD;
    logic [6:0]  pipeIdReg3;
    logic [63:0] pipeData3;
    logic        rfIsWr;
    logic        rfIsQw;
    logic [6:0]  rfIdRegD;
    logic [63:0] rfDataD;
    logic [6:0]  rfIdReg3;
    logic [63:0] rfData3;

    logic [63:0] gprMem [128];
    logic [63:0] expMem [128];
    logic        ovr;
    logic [63:0] ovrData;
    logic        expBank;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpreg_bank_swap dut (
        .clk(clk), .reset(reset), .reqBank(reqBank), .curBank(curBank),
        .swapBusy(swapBusy), .dropErr(dropErr),
        .pipeIsWr(pipeIsWr), .pipeIsQw(pipeIsQw), .pipeIdRegD(pipeIdRegD),
        .pipeDataD(pipeDataD), .pipeIdReg3(pipeIdReg3), .pipeData3(pipeData3),
        .rfIsWr(rfIsWr), .rfIsQw(rfIsQw), .rfIdRegD(rfIdRegD), .rfDataD(rfDataD),
        .rfIdReg3(rfIdReg3), .rfData3(rfData3)
    );

    // GPR file: combinational read port 3, clocked write port (low 32 bits when not quadword)
    assign rfData3 = ovr ? ovrData : gprMem[rfIdReg3];
    always @(posedge clk) begin
        if (rfIsWr)
            gprMem[rfIdRegD] <= rfIsQw ? rfDataD : {gprMem[rfIdRegD][63:32], rfDataD[31:0]};
    end

    typedef struct {
        logic        isWr;
        logic        isQw;
        logic [6:0]  idD;
        logic [63:0] dataD;
        logic [6:0]  id3;
        logic [63:0] d3;
        logic        eIsWr;
        logic        eIsQw;
        logic [6:0]  eIdD;
        logic [63:0] eDataD;
        logic [6:0]  eId3;
        logic [63:0] eData3;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference write rule of the register file
    task automatic expWrite(input logic [6:0] id, input logic qw, input logic [63:0] d);
        expMem[id] = qw ? d : {expMem[id][63:32], d[31:0]};
    endtask

    // Reference effect of one complete bank swap
    task automatic expSwap();
        logic [63:0] t;
        for (int i = 0; i < NP; i++) begin
            t = expMem[7'(RB + 7'(i))];
            expMem[7'(RB + 7'(i))] = expMem[7'(BB + 7'(i))];
            expMem[7'(BB + 7'(i))] = t;
        end
        expBank = ~expBank;
    endtask

    task automatic memCheck(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < 128; i++)
            if (bad < 0 && gprMem[i] !== expMem[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: reg %0d got %h expected %h", name, bad, gprMem[bad], expMem[bad]);
        end
    endtask

    task automatic initMem();
        for (int i = 0; i < 128; i++) begin
            gprMem[i] <= 64'h0;
            expMem[i] = 64'h0;
        end
        for (int i = 0; i < NP; i++) begin
            gprMem[RB + 7'(i)] <= 64'h100 + 64'(i);
            gprMem[BB + 7'(i)] <= 64'h200 + 64'(i);
            expMem[RB + 7'(i)] = 64'h100 + 64'(i);
            expMem[BB + 7'(i)] = 64'h200 + 64'(i);
        end
    endtask

    // Caller changed reqBank after a posedge; runs until the first idle cycle,
    // returns the busy-cycle count; optionally drops a write or flips reqBank
    task automatic swapCycles(input int dropAt, input int toggleAt, output int n);
        int c;
        n = 0;
        c = 0;
        @(posedge clk);
        while (1) begin
            #1;
            c++;
            pipeIsWr   = (c == dropAt);
            pipeIsQw   = (c == dropAt);
            pipeIdRegD = 7'h03;
            pipeDataD  = 64'hDEAD;
            if (c == toggleAt) reqBank = ~reqBank;
            @(negedge clk);
            if (c == dropAt) chk("drop_pulse", 64'(dropErr), 64'd1);
            if (dropAt > 0 && c == dropAt + 1) chk("drop_single", 64'(dropErr), 64'd0);
            if (!swapBusy) break;
            n++;
            if (c >= 200) begin
                chk("swap_timeout", 64'(swapBusy), 64'd0);
                break;
            end
            @(posedge clk);
        end
        pipeIsWr = 1'b0;
        pipeIsQw = 1'b0;
    endtask

    task automatic fullSwap(input string name, input int dropAt);
        int n;
        reqBank = ~reqBank;
        swapCycles(dropAt, 0, n);
        expSwap();
        chk({name, "_busy"}, 64'(n), 64'(BUSY));
        chk({name, "_bank"}, 64'(curBank), 64'(expBank));
        memCheck({name, "_mem"});
    endtask

    initial begin
        int n;
        reset = 1'b1; reqBank = 1'b0; ovr = 1'b0; ovrData = '0;
        pipeIsWr = 1'b0; pipeIsQw = 1'b0; pipeIdRegD = '0; pipeDataD = '0; pipeIdReg3 = '0;
        expBank = 1'b0;
        initMem();

        tbl[0] = '{1'b0, 1'b0, 7'h00, 64'h0, 7'h51, 64'h1234,
                   1'b0, 1'b0, 7'h00, 64'h0, 7'h51, 64'h1234};
        tbl[1] = '{1'b1, 1'b1, 7'h05, 64'hCAFE_F00D_1234_5678, 7'h05, 64'h77,
                   1'b1, 1'b1, 7'h05, 64'hCAFE_F00D_1234_5678, 7'h05, 64'h77};
        tbl[2] = '{1'b1, 1'b0, 7'h60, 64'hFFFF_0000_AAAA_5555, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFF,
                   1'b1, 1'b0, 7'h60, 64'hFFFF_0000_AAAA_5555, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[3] = '{1'b0, 1'b1, 7'h58, 64'h1, 7'h00, 64'h0,
                   1'b0, 1'b1, 7'h58, 64'h1, 7'h00, 64'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(swapBusy), 64'd0);
        chk("rst_bank", 64'(curBank), 64'd0);
        chk("rst_drop", 64'(dropErr), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Bank 0 -> 1 and back
        fullSwap("swap01", 0);
        chk("swap01_r0", gprMem[0], 64'h200);
        chk("swap01_cc8", gprMem[7'h58], 64'h100);
        fullSwap("swap10", 0);
        chk("swap10_r7", gprMem[7], 64'h107);

        // Pipeline write in busy cycle 5 is dropped
        fullSwap("drop", 5);
        fullSwap("dropback", 0);

        // reqBank flips back mid-swap: one full swap, then another immediately
        reqBank = 1'b1;
        swapCycles(0, 4, n);
        expSwap();
        chk("dbl_busy1", 64'(n), 64'(BUSY));
        chk("dbl_bank1", 64'(curBank), 64'd1);
        swapCycles(0, 0, n);
        expSwap();
        chk("dbl_busy2", 64'(n), 64'(BUSY));
        chk("dbl_bank2", 64'(curBank), 64'd0);
        memCheck("dbl_mem");

        // Reset in busy cycle 10
        @(posedge clk); #1;
        reqBank = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstmid_pre_busy", 64'(swapBusy), 64'd1);
        reset = 1'b1;
        reqBank = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        pipeIsWr = 1'b1; pipeIsQw = 1'b1; pipeIdRegD = 7'h10; pipeDataD = 64'h55; pipeIdReg3 = 7'h22;
        @(negedge clk);
        chk("rstmid_busy", 64'(swapBusy), 64'd0);
        chk("rstmid_bank", 64'(curBank), 64'd0);
        chk("rstmid_id3", 64'(rfIdReg3), 64'h22);
        chk("rstmid_wr", 64'({rfIsWr, rfIsQw, rfIdRegD}), 64'({1'b1, 1'b1, 7'h10}));
        chk("rstmid_data", rfDataD, 64'h55);
        pipeIsWr = 1'b0;
        expBank = 1'b0;
        initMem();
        @(posedge clk); #1;

        // Idle pass-through vectors
        ovr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pipeIsWr = tbl[k].isWr; pipeIsQw = tbl[k].isQw; pipeIdRegD = tbl[k].idD;
            pipeDataD = tbl[k].dataD; pipeIdReg3 = tbl[k].id3; ovrData = tbl[k].d3;
            @(negedge clk);
            chk($sformatf("pt%0d_data3", k), pipeData3, tbl[k].eData3);
            chk($sformatf("pt%0d_id3", k), 64'(rfIdReg3), 64'(tbl[k].eId3));
            chk($sformatf("pt%0d_wr", k), 64'({rfIsWr, rfIsQw, rfIdRegD}),
                64'({tbl[k].eIsWr, tbl[k].eIsQw, tbl[k].eIdD}));
            chk($sformatf("pt%0d_dataD", k), rfDataD, tbl[k].eDataD);
            if (tbl[k].isWr) expWrite(tbl[k].idD, tbl[k].isQw, tbl[k].dataD);
            @(posedge clk); #1;
        end
        ovr = 1'b0;
        pipeIsWr = 1'b0;
        @(posedge clk); #1;
        memCheck("pt_mem");

        // Randomized mix of idle writes/reads and bank swaps
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) != 0) begin
                logic [6:0]  id;
                logic [6:0]  rd;
                logic        qw;
                logic [63:0] d;
                id = 7'($urandom_range(0, 127));
                rd = 7'($urandom_range(0, 127));
                qw = 1'($urandom_range(0, 1));
                d  = {$urandom, $urandom};
                pipeIsWr = 1'b1; pipeIsQw = qw; pipeIdRegD = id; pipeDataD = d; pipeIdReg3 = rd;
                @(negedge clk);
                chk("rnd_read", pipeData3, expMem[rd]);
                expWrite(id, qw, d);
                @(posedge clk); #1;
                pipeIsWr = 1'b0;
            end else begin
                fullSwap("rnd_swap", 0);
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        memCheck("rnd_mem");
        chk("rnd_bank", 64'(curBank), 64'(expBank));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
